// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game sequencer.
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADD      = 3'd1,
    SHOW_ON  = 3'd2,
    SHOW_OFF = 3'd3,
    WAIT_IN  = 3'd4,
    LOSE     = 3'd5,
    WIN      = 3'd6
  } simonState_t;

  typedef logic [1:0] colour_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Feedback bit of the 16-bit Fibonacci LFSR with taps 16,14,13,11.
  function automatic logic lfsrFeedback(input logic [15:0] s);
    return s[15] ^ s[13] ^ s[12] ^ s[10];
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Fibonacci LFSR that supplies the random colours.
module simon_lfsr
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);

  logic [15:0] stateNext;

  // Shift in the feedback bit; a corrupted all-zero state is steered back to the seed.
  always_comb begin
    if (state == 16'h0000) begin
      stateNext = LFSR_SEED;
    end else begin
      stateNext = {state[14:0], lfsrFeedback(state)};
    end
  end

  // State register, advancing every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LFSR_SEED;
    end else begin
      state <= stateNext;
    end
  end

endmodule

// File: rtl/simon_sequencer.sv
// Simon game sequencer: grows a random colour sequence, plays it back on
// tick strobes and checks the player's presses against it.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int MAX_LEN       = 32,
  parameter int ON_TICKS      = 30,
  parameter int OFF_TICKS     = 15,
  parameter int TIMEOUT_TICKS = 180
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       btn_valid,
  input  logic [1:0] btn_num,
  output logic       show_valid,
  output logic [1:0] show_num,
  output logic       player_turn,
  output logic [5:0] level,
  output logic       game_over,
  output logic       win
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CNT_W = $clog2(ON_TICKS + OFF_TICKS + TIMEOUT_TICKS + 1);
  localparam logic [CNT_W-1:0] ON_LAST      = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST     = CNT_W'(OFF_TICKS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [5:0]       LEN_MAX      = 6'(MAX_LEN);

  simonState_t      stateR, stateNext;
  logic [5:0]       lengthR, lengthNext;
  logic [5:0]       idxR, idxNext;
  logic [5:0]       lastIdx;
  logic [CNT_W-1:0] tickCntR, tickCntNext;
  logic             memWe;
  colour_t          mem [MAX_LEN];
  colour_t          curColour;
  logic [15:0]      lfsrState;
  logic             unusedLfsr;

  simon_lfsr uLfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsrState)
  );

  assign unusedLfsr = ^lfsrState[15:2];
  assign curColour  = mem[idxR[IDX_W-1:0]];
  assign lastIdx    = lengthR - 6'd1;

  // Outputs are decoded from registered state only.
  assign show_valid  = (stateR == SHOW_ON);
  assign show_num    = show_valid ? curColour : 2'd0;
  assign player_turn = (stateR == WAIT_IN);
  assign level       = lengthR;
  assign game_over   = (stateR == LOSE);
  assign win         = (stateR == WIN);

  // Next-state and datapath update; the tick counter is cleared on every state change.
  always_comb begin
    stateNext   = stateR;
    lengthNext  = lengthR;
    idxNext     = idxR;
    tickCntNext = tickCntR;
    memWe       = 1'b0;
    case (stateR)
      IDLE, LOSE, WIN: begin
        if (start) begin
          stateNext   = ADD;
          lengthNext  = 6'd0;
          tickCntNext = CNT_ZERO;
        end else begin
          stateNext = stateR;
        end
      end
      ADD: begin
        memWe       = 1'b1;
        lengthNext  = lengthR + 6'd1;
        idxNext     = 6'd0;
        tickCntNext = CNT_ZERO;
        stateNext   = SHOW_ON;
      end
      SHOW_ON: begin
        if (tick) begin
          if (tickCntR == ON_LAST) begin
            stateNext   = SHOW_OFF;
            tickCntNext = CNT_ZERO;
          end else begin
            tickCntNext = tickCntR + CNT_ONE;
          end
        end else begin
          tickCntNext = tickCntR;
        end
      end
      SHOW_OFF: begin
        if (tick) begin
          if (tickCntR == OFF_LAST) begin
            tickCntNext = CNT_ZERO;
            if (idxR == lastIdx) begin
              stateNext = WAIT_IN;
              idxNext   = 6'd0;
            end else begin
              stateNext = SHOW_ON;
              idxNext   = idxR + 6'd1;
            end
          end else begin
            tickCntNext = tickCntR + CNT_ONE;
          end
        end else begin
          tickCntNext = tickCntR;
        end
      end
      WAIT_IN: begin
        // A press in the same cycle as the expiring tick wins over the timeout.
        if (btn_valid) begin
          tickCntNext = CNT_ZERO;
          if (btn_num != curColour) begin
            stateNext = LOSE;
          end else if (idxR == lastIdx) begin
            stateNext = (lengthR == LEN_MAX) ? WIN : ADD;
          end else begin
            idxNext = idxR + 6'd1;
          end
        end else if (tick) begin
          if (tickCntR == TIMEOUT_LAST) begin
            stateNext   = LOSE;
            tickCntNext = CNT_ZERO;
          end else begin
            tickCntNext = tickCntR + CNT_ONE;
          end
        end else begin
          tickCntNext = tickCntR;
        end
      end
      default: begin
        stateNext   = IDLE;
        lengthNext  = 6'd0;
        idxNext     = 6'd0;
        tickCntNext = CNT_ZERO;
      end
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateR   <= IDLE;
      lengthR  <= 6'd0;
      idxR     <= 6'd0;
      tickCntR <= CNT_ZERO;
    end else begin
      stateR   <= stateNext;
      lengthR  <= lengthNext;
      idxR     <= idxNext;
      tickCntR <= tickCntNext;
    end
  end

  // Sequence memory; never read beyond the current length, so it needs no reset.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[lengthR[IDX_W-1:0]] <= lfsrState[1:0];
    end
  end

endmodule

// File: doc/simon_sequencer.md
SIMON_SEQUENCER -- requirements
Module: simon_sequencer

Interface
REQ-001 Parameter MAX_LEN, 32, maximum sequence length (colours).
REQ-002 Parameter ON_TICKS, 30, ticks a colour is shown.
REQ-003 Parameter OFF_TICKS, 15, dark ticks between shown colours.
REQ-004 Parameter TIMEOUT_TICKS, 180, ticks allowed per player press.
REQ-005 clk  in  1  system clock.
REQ-006 reset  in  1  reset, asynchronous, active-high.
REQ-007 tick  in  1  single-cycle timing strobe (60 Hz).
REQ-008 start  in  1  single-cycle pulse, begin a new game.
REQ-009 btn_valid  in  1  single-cycle pulse, player pressed a button.
REQ-010 btn_num  in  2  colour of the player press, valid with btn_valid.
REQ-011 show_valid  out  1  colour lamp on during playback.
REQ-012 show_num  out  2  colour being shown.
REQ-013 player_turn  out  1  sequencer awaits player input.
REQ-014 level  out  6  current sequence length.
REQ-015 game_over  out  1  player lost, held until start.
REQ-016 win  out  1  MAX_LEN rounds completed, held until start.

Function
REQ-017 FSM states: IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, LOSE, WIN.
REQ-018 IDLE/LOSE/WIN + start -> ADD; length cleared to 0 in the same cycle; start is ignored in every other state.
REQ-019 ADD (one cycle): mem[length] <= lfsr[1:0]; length <= length+1; idx <= 0; tick counter cleared; -> SHOW_ON.
REQ-020 SHOW_ON: show_valid=1, show_num=mem[idx]; after ON_TICKS tick strobes -> SHOW_OFF.
REQ-021 SHOW_OFF: show_valid=0; after OFF_TICKS tick strobes: idx==length-1 -> WAIT_IN with idx=0, else idx+1 -> SHOW_ON.
REQ-022 Tick counter clears on every state entry; only cycles with tick=1 count.
REQ-023 WAIT_IN: player_turn=1; btn_valid with btn_num==mem[idx]: idx==length-1 -> (length==MAX_LEN ? WIN : ADD), else idx+1 and timeout counter cleared.
REQ-024 WAIT_IN: btn_valid with btn_num!=mem[idx] -> LOSE.
REQ-025 WAIT_IN: TIMEOUT_TICKS ticks with no btn_valid -> LOSE; btn_valid in the same cycle as the expiring tick takes priority over timeout.
REQ-026 btn_valid outside WAIT_IN is ignored and does not affect state.
REQ-027 LOSE: game_over=1; WIN: win=1; both otherwise 0.
REQ-028 level = length (0..MAX_LEN); no wrap; ADD is unreachable when length==MAX_LEN.
REQ-029 show_num=0 whenever show_valid=0; player_turn=0 outside WAIT_IN.
REQ-030 LFSR 16-bit Fibonacci, taps 16,14,13,11, advances every clk cycle regardless of state; never all-zero.
REQ-031 All outputs are registered or decoded from the registered state; no input-to-output combinational path.

Reset
REQ-032 Reset asserted: state=IDLE, length=0, idx=0, counters=0, LFSR=16'hACE1, all outputs 0.
REQ-033 Reset mid-game aborts immediately; mem contents need not be cleared (never read beyond length).

Structure
REQ-034 simon_pkg holds the state enum, the 2-bit colour type and the LFSR seed constant.
REQ-035 Sub-module simon_lfsr (clk, reset, 16-bit state out); mem is a MAX_LEN x 2 register array inside simon_sequencer.

Verification (ON_TICKS=2, OFF_TICKS=1, TIMEOUT_TICKS=4, MAX_LEN=3, tick every 4 clks)
REQ-036 Reset then start -> level=1 one cycle later; show_valid high for exactly 2 ticks; then player_turn=1.
REQ-037 Level 1, press the correct colour -> ADD, level=2, playback of mem[0],mem[1] in order with a 1-tick gap.
REQ-038 Level 2, correct first press, wrong second press -> game_over=1 next cycle; player_turn=0; start -> level=1, game_over=0.
REQ-039 WAIT_IN with no press for 4 ticks -> game_over=1; press coinciding with the 4th tick -> accepted, no game_over.
REQ-040 Three correct rounds -> win=1 at level=3; btn_valid and presses during SHOW states change nothing.
REQ-041 Reset asserted during SHOW_ON -> all outputs 0 asynchronously; after release, start restarts at level=1.
